flatten_stream_ctrl: RTL
========================

# flatten_stream_ctrl

Sequencer that sits between the pooling stage and the fully-connected stage. It captures one pooled feature map (POOL_OFMAP_SIZE × POOL_OFMAP_SIZE) per handshake and streams it out one pixel per cycle in row-major order, which matches the flatten ordering. It tracks channels so that the FC stage receives a global feature index and an end-of-image marker. It replaces the all-at-once parallel flatten on the FC path with a valid/ready stream.

## Interface
- DATA_WIDTH, 8, pixel width
- POOL_OFMAP_SIZE, 2, side length of the pooled map
- NUM_CHANNELS, 4, feature maps per image
- POOL_PIXEL_COUNT, POOL_OFMAP_SIZE*POOL_OFMAP_SIZE, derived; not to be overridden
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- clear  in  1  synchronous abort; returns to IDLE with counters zeroed
- in_feature  in  [DATA_WIDTH-1:0] [0:POOL_OFMAP_SIZE-1][0:POOL_OFMAP_SIZE-1]  pooled map
- in_valid  in  1  in_feature is valid
- in_ready  out  1  block accepts a map this cycle
- out_data  out  DATA_WIDTH  current flattened pixel
- out_valid  out  1  out_data is valid
- out_ready  in  1  downstream accepts the pixel
- out_index  out  $clog2(NUM_CHANNELS*POOL_PIXEL_COUNT)  global index, ch*POOL_PIXEL_COUNT+pix
- out_last  out  1  final pixel of the final channel
- image_done  out  1  one-cycle pulse after the out_last beat is accepted
- busy  out  1  state is STREAM

## Operation
- Definitions:
  - in_fire = in_valid & in_ready
  - out_fire = out_valid & out_ready
- Storage:
  - One map buffer.
  - pix counter, range 0..POOL_PIXEL_COUNT-1.
  - ch counter, range 0..NUM_CHANNELS-1.
- FSM states: IDLE, STREAM.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_fire: buffer is loaded, pix=0, go to STREAM.
- STREAM:
  - out_valid=1.
  - out_data = buf[pix/POOL_OFMAP_SIZE][pix%POOL_OFMAP_SIZE].
  - out_index = ch*POOL_PIXEL_COUNT+pix.
  - out_last = (pix==POOL_PIXEL_COUNT-1) && (ch==NUM_CHANNELS-1).
- On out_fire with pix below the last pixel: pix increments.
- On out_fire with pix at the last pixel:
  - pix goes to 0.
  - ch increments, or wraps to 0 if it is at NUM_CHANNELS-1.
  - If in_fire occurs in the same cycle, the buffer is reloaded and the state stays STREAM (no bubble).
  - Otherwise the state goes to IDLE.
- in_ready = IDLE | (STREAM & pix==POOL_PIXEL_COUNT-1 & out_ready). This is a combinational path from out_ready.
- out_ready low: out_data, out_index and out_last hold stable, and out_valid stays high.
- in_valid in STREAM before the last beat is ignored. The upstream holds the map until in_ready.
- clear has priority over every other event:
  - Next state is IDLE; pix, ch and image_done go to 0.
  - A simultaneous in_fire is discarded. In IDLE, in_ready is still high that cycle, so the upstream must not count the transfer while clear is asserted.
- ch is not reset between images except by rst_n, clear, or the wrap.

## Timing
- Reset values:
  - State IDLE, so in_ready=1 and busy=0.
  - out_valid=0, out_data=0, out_index=0, out_last=0, image_done=0.
  - pix=0, ch=0.
  - Buffer contents are don't-care.
- Latency: in_fire at edge T puts pixel 0 on the outputs from T+1.
- Throughput with out_ready held high:
  - POOL_PIXEL_COUNT cycles per map.
  - Back-to-back maps stream continuously with no idle cycle.
- image_done is registered and high for exactly the cycle after the edge at which the out_last beat fires.
- rst_n asserted mid-stream: all state clears immediately (asynchronous); the partial image is lost.

## Structure
- Shared package (cnn_defs.svh) holds DATA_WIDTH, POOL_OFMAP_SIZE, POOL_PIXEL_COUNT, NUM_CHANNELS, and the typedef for the state enum (IDLE, STREAM).
- One natural sub-module: flatten_pixel_mux. It is combinational; given the buffer and pix, it selects the row-major element.
- Counters and the FSM stay in the top level.

## Test plan
- Single map, out_ready=1:
  - Stimulus: maps [[1,2],[3,4]], NUM_CHANNELS=1.
  - Required response: out_data 1,2,3,4 on consecutive cycles; out_index 0..3; out_last on the 4th beat; image_done one cycle later; then IDLE.
- Four channels back-to-back, in_valid held high:
  - Stimulus: channel c pixel p = 16c+p.
  - Required response: 16 contiguous beats; out_index 0..15; no bubble; out_last only at index 15.
- Backpressure:
  - Stimulus: out_ready low on the 2nd beat for 3 cycles.
  - Required response: out_data=2 and out_index=1 held stable; out_valid stays 1; in_ready stays 0.
- Early in_valid:
  - Stimulus: in_valid asserted on pix=0 with a new map.
  - Required response: not accepted until the last-beat cycle; the first map streams unaltered.
- clear mid-stream:
  - Stimulus: clear at pix=2 of channel 1.
  - Required response: next cycle out_valid=0 and in_ready=1; the next map restarts at out_index 0.
- rst_n low mid-stream:
  - Required response: out_valid, out_index and image_done drop to 0 without waiting for a clock edge.

Source files
------------

// File: rtl/flatten_stream_ctrl_pkg.sv
// Shared defaults and types for the pooled-map flatten sequencer.
// The FC-side stream is produced by flatten_stream_ctrl.
package flatten_stream_ctrl_pkg;

  localparam int DATA_WIDTH       = 8;
  localparam int POOL_OFMAP_SIZE  = 2;
  localparam int NUM_CHANNELS     = 4;
  localparam int POOL_PIXEL_COUNT = POOL_OFMAP_SIZE * POOL_OFMAP_SIZE;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  // Counter width that never collapses to zero bits for single-entry ranges.
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/flatten_pixel_mux.sv
// Combinational row-major selector: picks map[pix / SIZE][pix % SIZE].
module flatten_pixel_mux
  import flatten_stream_ctrl_pkg::*;
#(
  parameter int DW    = 8,
  parameter int SIZE  = 2,
  parameter int PIX_W = 2
) (
  input  logic [DW-1:0]    map [0:SIZE-1][0:SIZE-1],
  input  logic [PIX_W-1:0] pix,
  output logic [DW-1:0]    pixel
);

  // Compare against each flat position instead of dividing by SIZE.
  always_comb begin
    pixel = '0;
    for (int r = 0; r < SIZE; r++) begin
      for (int c = 0; c < SIZE; c++) begin
        if (pix == PIX_W'(r * SIZE + c)) begin
          pixel = map[r][c];
        end
      end
    end
  end

endmodule

// File: rtl/flatten_stream_ctrl.sv
// Captures one pooled map per handshake and streams it pixel by pixel with a
// global feature index and an end-of-image marker for the FC stage.
module flatten_stream_ctrl #(
  parameter int DATA_WIDTH      = flatten_stream_ctrl_pkg::DATA_WIDTH,
  parameter int POOL_OFMAP_SIZE = flatten_stream_ctrl_pkg::POOL_OFMAP_SIZE,
  parameter int NUM_CHANNELS    = flatten_stream_ctrl_pkg::NUM_CHANNELS,
  localparam int POOL_PIXEL_COUNT = POOL_OFMAP_SIZE * POOL_OFMAP_SIZE,
  localparam int IDX_W = flatten_stream_ctrl_pkg::width_of(NUM_CHANNELS * POOL_PIXEL_COUNT)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] in_feature [0:POOL_OFMAP_SIZE-1][0:POOL_OFMAP_SIZE-1],
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [IDX_W-1:0]      out_index,
  output logic                  out_last,
  output logic                  image_done,
  output logic                  busy
);

  import flatten_stream_ctrl_pkg::*;

  localparam int PIX_W = width_of(POOL_PIXEL_COUNT);
  localparam int CH_W  = width_of(NUM_CHANNELS);
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(POOL_PIXEL_COUNT - 1);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CHANNELS - 1);

  // Handshakes: a beat transfers on a rising edge where valid and ready are
  // both high; valid never depends on ready, and in_ready may depend on out_ready.
  state_t                state;
  logic [PIX_W-1:0]      pix;
  logic [CH_W-1:0]       ch;
  logic [DATA_WIDTH-1:0] map_buf [0:POOL_OFMAP_SIZE-1][0:POOL_OFMAP_SIZE-1];
  logic [DATA_WIDTH-1:0] pixel;
  logic                  at_last_pix;
  logic                  in_fire;
  logic                  out_fire;
  logic                  load;

  assign at_last_pix = (pix == PIX_LAST);
  assign out_valid   = (state == STREAM);
  assign busy        = (state == STREAM);
  assign in_ready    = (state == IDLE) || ((state == STREAM) && at_last_pix && out_ready);
  assign in_fire     = in_valid && in_ready;
  assign out_fire    = out_valid && out_ready;
  assign load        = in_fire && !clear;

  // Map contents need no reset; they are only observed while streaming.
  always_ff @(posedge clk) begin
    if (load) begin
      map_buf <= in_feature;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pix        <= '0;
      ch         <= '0;
      image_done <= 1'b0;
    end else if (clear) begin
      state      <= IDLE;
      pix        <= '0;
      ch         <= '0;
      image_done <= 1'b0;
    end else begin
      image_done <= 1'b0;
      case (state)
        IDLE: begin
          if (in_fire) begin
            pix   <= '0;
            state <= STREAM;
          end
        end
        STREAM: begin
          if (out_fire) begin
            if (!at_last_pix) begin
              pix <= pix + 1'b1;
            end else begin
              pix        <= '0;
              ch         <= (ch == CH_LAST) ? '0 : ch + 1'b1;
              image_done <= (ch == CH_LAST);
              // A map accepted on the last beat continues without a bubble.
              state      <= in_fire ? STREAM : IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  flatten_pixel_mux #(
    .DW    (DATA_WIDTH),
    .SIZE  (POOL_OFMAP_SIZE),
    .PIX_W (PIX_W)
  ) u_pixel_mux (
    .map   (map_buf),
    .pix   (pix),
    .pixel (pixel)
  );

  assign out_data  = out_valid ? pixel : '0;
  assign out_index = out_valid ? (IDX_W'(ch) * IDX_W'(POOL_PIXEL_COUNT) + IDX_W'(pix)) : '0;
  assign out_last  = out_valid && at_last_pix && (ch == CH_LAST);

endmodule
